// File: rtl/conv_unit_sequencer.sv
// conv_unit_sequencer
//   Initiator side of the conv-unit interface. For every (filter, depth) pass
//   it loads K*K weights into the weight FIFO, streams the IFM plane for that
//   depth into the line-buffer FIFO, raises conv_enable for each pixel that
//   completes a valid KxK window, and issues the OFM write strobe/address for
//   each convolution result. Pass order: filter outer, depth inner.
//
//   Optional build macro: CONV_SEQ_PAUSE_EN adds a 'pause' input that freezes
//   the FSM, the counters and new read strobes. Pushes of reads that were
//   already issued and the conv->ofm delay line keep moving.
//
// Ports
//   clk, reset          single rising-edge clock, synchronous active-high reset
//   pause               (CONV_SEQ_PAUSE_EN only) stall request
//   start               pulse, begins a full layer; ignored while busy
//   busy                high from the cycle after an accepted start until done
//   done                one-cycle pulse after the final OFM write of the layer
//   wm_enable_read      weight-memory read strobe, address on wm_address
//   wm_fifo_enable      weight FIFO shift, one cycle after each weight read
//   ifm_enable_read     IFM read strobe, address on ifm_address
//   fifo_enable         line-buffer shift, one cycle after each IFM read
//   conv_enable         a valid window sits in the line buffer
//   ofm_enable_write    unit_data_out is valid; write it to ofm_address
//   ofm_accumulate      write adds to a stored partial sum (depth != 0)
//   state_dbg           current FSM state (see state_t encoding)
//
// Strobe semantics: every strobe here is a one-cycle, valid-only qualifier
// with no back-pressure. A strobe high in a cycle means exactly one
// transfer happens in that cycle with the address presented alongside it.

module conv_unit_sequencer #(
  parameter int ADDRESS_BITS      = 16,
  parameter int IFM_SIZE          = 32,
  parameter int IFM_DEPTH         = 3,
  parameter int KERNAL_SIZE       = 5,
  parameter int NUMBER_OF_FILTERS = 6,
  parameter int CONV_LATENCY      = 3,
  localparam int IFM_SIZE_NEXT         = IFM_SIZE - KERNAL_SIZE + 1,
  localparam int ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE * IFM_DEPTH),
  localparam int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT)
) (
  input  logic                             clk,
  input  logic                             reset,
`ifdef CONV_SEQ_PAUSE_EN
  input  logic                             pause,
`endif
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic                             wm_enable_read,
  output logic [ADDRESS_BITS-1:0]          wm_address,
  output logic                             wm_fifo_enable,
  output logic                             ifm_enable_read,
  output logic [ADDRESS_SIZE_IFM-1:0]      ifm_address,
  output logic                             fifo_enable,
  output logic                             conv_enable,
  output logic                             ofm_enable_write,
  output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ofm_address,
  output logic                             ofm_accumulate,
  output logic [2:0]                       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int KK = KERNAL_SIZE * KERNAL_SIZE;
  localparam int KW = $clog2(KK + 1);
  localparam int CW = $clog2(IFM_SIZE + 1);
  localparam int FW = $clog2(NUMBER_OF_FILTERS + 1);
  localparam int DW = $clog2(IFM_DEPTH + 1);

  localparam logic [KW-1:0] K_LAST   = KW'(KK - 1);
  localparam logic [CW-1:0] P_LAST   = CW'(IFM_SIZE - 1);
  localparam logic [CW-1:0] WIN_MIN  = CW'(KERNAL_SIZE - 1);
  localparam logic [FW-1:0] F_LAST   = FW'(NUMBER_OF_FILTERS - 1);
  localparam logic [DW-1:0] D_LAST   = DW'(IFM_DEPTH - 1);
  localparam logic [ADDRESS_SIZE_IFM-1:0] PLANE = ADDRESS_SIZE_IFM'(IFM_SIZE * IFM_SIZE);
  // All delay-line stages except the last (the one driving the write).
  localparam logic [CONV_LATENCY-1:0] DLY_EARLY = {CONV_LATENCY{1'b1}} >> 1;

  state_t                           state;
  logic [KW-1:0]                    kcnt;
  logic [CW-1:0]                    row;
  logic [CW-1:0]                    col;
  logic [FW-1:0]                    f_idx;
  logic [DW-1:0]                    d_idx;
  logic [ADDRESS_SIZE_IFM-1:0]      ifm_base;
  logic                             push_win;
  logic [CONV_LATENCY-1:0]          dly;
  logic [CONV_LATENCY-1:0]          acc_dly;
  logic [ADDRESS_SIZE_NEXT_IFM-1:0] ofm_idx;
  logic                             adv;
  logic                             drain_pending;

`ifdef CONV_SEQ_PAUSE_EN
  assign adv = ~pause;
`else
  assign adv = 1'b1;
`endif

  assign state_dbg        = state;
  assign ofm_enable_write = dly[CONV_LATENCY-1];
  assign ofm_accumulate   = acc_dly[CONV_LATENCY-1];
  assign ofm_address      = ofm_idx;

  // Anything still in flight that will produce a later write. The final
  // write of a pass is the only window left once this drops, so leaving
  // DRAIN on that edge puts the next pass the cycle after the final write.
  assign drain_pending = push_win | conv_enable | (|(dly & DLY_EARLY));

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      wm_enable_read  <= 1'b0;
      wm_address      <= '0;
      wm_fifo_enable  <= 1'b0;
      ifm_enable_read <= 1'b0;
      ifm_address     <= '0;
      fifo_enable     <= 1'b0;
      conv_enable     <= 1'b0;
      kcnt            <= '0;
      row             <= '0;
      col             <= '0;
      f_idx           <= '0;
      d_idx           <= '0;
      ifm_base        <= '0;
      push_win        <= 1'b0;
      dly             <= '0;
      acc_dly         <= '0;
      ofm_idx         <= '0;
    end else begin
      // Pipeline behind issued reads: never stalls.
      wm_fifo_enable <= wm_enable_read;
      fifo_enable    <= ifm_enable_read;
      // row/col describe the pixel currently being read.
      push_win       <= ifm_enable_read && (row >= WIN_MIN) && (col >= WIN_MIN);
      conv_enable    <= push_win;
      dly[0]         <= conv_enable;
      acc_dly[0]     <= conv_enable && (d_idx != '0);
      for (int i = 1; i < CONV_LATENCY; i++) begin
        dly[i]     <= dly[i-1];
        acc_dly[i] <= acc_dly[i-1];
      end
      if (ofm_enable_write) ofm_idx <= ofm_idx + ADDRESS_SIZE_NEXT_IFM'(1);
      done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state          <= S_LOAD_W;
            busy           <= 1'b1;
            wm_enable_read <= 1'b1;
            wm_address     <= '0;
            kcnt           <= '0;
            f_idx          <= '0;
            d_idx          <= '0;
            ifm_base       <= '0;
            ofm_idx        <= '0;
          end
        end

        // The read on wm_address is issued in the current cycle; on each
        // advancing edge either issue the next one or hand over to STREAM.
        S_LOAD_W: begin
          if (adv) begin
            if (kcnt == K_LAST) begin
              state           <= S_STREAM;
              wm_enable_read  <= 1'b0;
              ifm_enable_read <= 1'b1;
              ifm_address     <= ifm_base;
              row             <= '0;
              col             <= '0;
            end else begin
              wm_enable_read <= 1'b1;
              wm_address     <= wm_address + ADDRESS_BITS'(1);
              kcnt           <= kcnt + KW'(1);
            end
          end else begin
            wm_enable_read <= 1'b0;
          end
        end

        S_STREAM: begin
          if (adv) begin
            if (row == P_LAST && col == P_LAST) begin
              state           <= S_DRAIN;
              ifm_enable_read <= 1'b0;
            end else begin
              ifm_enable_read <= 1'b1;
              ifm_address     <= ifm_address + ADDRESS_SIZE_IFM'(1);
              if (col == P_LAST) begin
                col <= '0;
                row <= row + CW'(1);
              end else begin
                col <= col + CW'(1);
              end
            end
          end else begin
            ifm_enable_read <= 1'b0;
          end
        end

        S_DRAIN: begin
          if (adv && !drain_pending) begin
            ofm_idx <= '0;
            if (f_idx == F_LAST && d_idx == D_LAST) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              // Weight addresses of consecutive passes are contiguous.
              state          <= S_LOAD_W;
              wm_enable_read <= 1'b1;
              wm_address     <= wm_address + ADDRESS_BITS'(1);
              kcnt           <= '0;
              if (d_idx == D_LAST) begin
                d_idx    <= '0;
                f_idx    <= f_idx + FW'(1);
                ifm_base <= '0;
              end else begin
                d_idx    <= d_idx + DW'(1);
                ifm_base <= ifm_base + PLANE;
              end
            end
          end
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
